rr_arb_mux: RTL
===============

RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data width per channel in bits (legal >= 1).
REQ-002 SHALL have parameter N, default 4, meaning number of input channels (legal >= 1).
REQ-003 SHALL derive local SELW = (N > 1) ? clog2(N) : 1, not overridable.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_data  input  N*WIDTH  channel k data at bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port in_valid  input  N  channel k offers a beat.
REQ-008 SHALL have port in_ready  output  N  channel k beat accepted this cycle.
REQ-009 SHALL have port out_data  output  WIDTH  registered selected data.
REQ-010 SHALL have port out_sel  output  SELW  index of the channel that supplied out_data.
REQ-011 SHALL have port out_valid  output  1  out_data/out_sel hold a beat.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the beat.

Function
REQ-013 SHALL define load_en = !out_valid || out_ready, combinational.
REQ-014 SHALL assert at most one in_ready bit per cycle, only when load_en=1 and that channel is the grant winner.
REQ-015 SHALL pick the winner as the first channel with in_valid=1, searching ptr, ptr+1, ... N-1, 0, ... ptr-1.
REQ-016 SHALL, on an accepted beat from channel k, load out_data=in_data[k], out_sel=k, out_valid=1 on the next edge (latency 1 cycle).
REQ-017 SHALL, on an accepted beat from channel k, set ptr=k+1, wrapping N-1 to 0; ptr SHALL stay unchanged in cycles with no grant.
REQ-018 SHALL clear out_valid on the edge where out_valid=1, out_ready=1 and no channel is granted.
REQ-019 SHALL hold out_data and out_sel stable while out_valid=1 and out_ready=0.
REQ-020 SHALL sustain one beat per cycle when out_ready is held at 1 and any in_valid is 1.
REQ-021 SHALL produce in_ready combinationally from in_valid, ptr, out_valid, out_ready, and lock state; no other path.
REQ-022 SHALL, for N=1, grant channel 0 whenever in_valid[0] and load_en are 1; out_sel SHALL be 0.

Reset
REQ-023 SHALL, while rst_n=0, force out_valid=0, out_data=0, out_sel=0, ptr=0, and all in_ready=0, independent of clk.
REQ-024 SHALL discard a held output beat and any burst lock when reset asserts mid-transfer; the first post-reset search SHALL start at channel 0.

Configuration
REQ-025 SHALL recognise macro RR_ARB_MUX_BURST_LOCK_EN.
REQ-026 SHALL, with the macro defined, add port in_last  input  N  channel k beat is final of its burst.
REQ-027 SHALL, with the macro defined, set locked=1, lock_ch=k on acceptance of a beat from k with in_last[k]=0.
REQ-028 SHALL, with the macro defined and locked=1, consider only lock_ch for grant; other in_valid bits SHALL be ignored.
REQ-029 SHALL, with the macro defined, clear locked on acceptance of a beat from lock_ch with in_last=1, and set ptr=lock_ch+1.
REQ-030 SHALL, with the macro defined, update ptr only when a burst closes, not on intermediate beats.
REQ-031 SHALL, with the macro undefined, have no in_last port and no lock state; every beat SHALL be arbitrated independently.

Verification
REQ-032 SHALL cover reset: rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, in_ready=0 without a clk edge; first grant after release goes to channel 0 if valid.
REQ-033 SHALL cover round-robin: N=4, in_valid=4'b1111, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3, one beat per cycle.
REQ-034 SHALL cover backpressure: out_valid=1, out_data=0xA5A5A5A5, out_ready=0 for 5 cycles -> out_data constant, in_ready=4'b0000; next edge with out_ready=1 loads the next winner.
REQ-035 SHALL cover wrap and skip: ptr=3, in_valid=4'b0101 -> channel 0 granted, ptr becomes 1; next grant goes to channel 2.
REQ-036 SHALL cover drain: single beat from channel 2, then in_valid=0, out_ready=1 -> out_valid high for exactly one cycle.
REQ-037 SHALL cover burst lock with macro defined: channel 1 sends 3 beats with in_last=0,0,1 while channel 2 is valid -> out_sel=1,1,1, then 2; ptr=2 after burst.

Source files
------------

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: round-robin arbiter feeding a single registered output stage.
// N input channels of WIDTH bits compete for one output beat per cycle. The
// search starts at a rotating pointer that moves past each winner.
// Optional feature: define RR_ARB_MUX_BURST_LOCK_EN to add the in_last port.
// With it, a channel keeps the grant until it delivers the final beat of its
// burst, and the pointer only advances when that burst closes.
module rr_arb_mux #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4,
    localparam int unsigned SELW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
`ifdef RR_ARB_MUX_BURST_LOCK_EN
    input  logic [N-1:0]         in_last,
`endif
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    output logic                 out_valid,
    input  logic                 out_ready
);

    // Rotating search start; always holds a value below N.
    logic [SELW-1:0]  r_ptr;

    logic             w_load_en;
    logic             w_found;
    logic             w_grant;
    logic [SELW-1:0]  w_win;
    logic [SELW-1:0]  w_next_ptr;
    logic [N-1:0]     w_cand;
    logic [WIDTH-1:0] w_win_data;

`ifdef RR_ARB_MUX_BURST_LOCK_EN
    typedef enum logic {
        LOCK_FREE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_t;

    lock_state_t      r_lock;
    logic [SELW-1:0]  r_lock_ch;
`endif

    // The output register can take a new beat when empty or being drained.
    assign w_load_en = !out_valid || out_ready;

    // Requesters eligible for the grant; a held burst masks all others.
    always_comb begin
        w_cand = in_valid;
`ifdef RR_ARB_MUX_BURST_LOCK_EN
        if (r_lock == LOCK_HELD) begin
            w_cand = '0;
            for (int unsigned i = 0; i < N; i++) begin
                if (SELW'(i) == r_lock_ch) begin
                    w_cand[i] = in_valid[i];
                end
            end
        end
`endif
    end

    // First eligible channel scanning ptr, ptr+1, ... with wrap to 0.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        w_found = 1'b0;
        w_win   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = 32'(r_ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!w_found && w_cand[idx]) begin
                w_found = 1'b1;
                w_win   = SELW'(idx);
            end
        end
    end

    // Reset gates the grant so in_ready is low while rst_n is asserted.
    assign w_grant = rst_n && w_load_en && w_found;

    // One-hot ready toward the winning channel only.
    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < N; i++) begin
            in_ready[i] = w_grant && (SELW'(i) == w_win);
        end
    end

    // Data of the winning channel.
    always_comb begin
        w_win_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (SELW'(i) == w_win) begin
                w_win_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Pointer value one past the winner, wrapping N-1 back to 0.
    assign w_next_ptr = (w_win == SELW'(N - 1)) ? '0 : w_win + SELW'(1);

    // Output stage: load on grant, drop valid when drained with nothing new.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
        end else if (w_grant) begin
            out_data  <= w_win_data;
            out_sel   <= w_win;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Pointer and burst-lock tracking, updated only on accepted beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr     <= '0;
`ifdef RR_ARB_MUX_BURST_LOCK_EN
            r_lock    <= LOCK_FREE;
            r_lock_ch <= '0;
`endif
        end else if (w_grant) begin
`ifdef RR_ARB_MUX_BURST_LOCK_EN
            // Intermediate beats lock the channel without moving the pointer;
            // only the closing beat advances it past the burst owner.
            if (in_last[w_win]) begin
                r_lock <= LOCK_FREE;
                r_ptr  <= w_next_ptr;
            end else begin
                r_lock    <= LOCK_HELD;
                r_lock_ch <= w_win;
            end
`else
            r_ptr <= w_next_ptr;
`endif
        end
    end

endmodule
